ram_read_streamer: RTL and testbench

Read-side sequencer that sits directly upstream of the consumer of a dual-port `ram` read port. On a `start` pulse it drives a strided address sequence into one RAM port with write-enable held low, absorbs the RAM's one-cycle registered read latency, and presents the returned words on a ready/valid stream toward the systolic-array feeder. A 4-entry output FIFO with credit-based issue lets it sustain one word per cycle and tolerate arbitrary backpressure without dropping any in-flight read.

---
 rtl/ram_read_streamer.sv | 142 ++++++++++++++
 tb/tb_ram_read_streamer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_read_streamer.sv
// Strided RAM read sequencer: issues read addresses on one RAM port, absorbs the
// one-cycle read latency and streams the returned words out through a 4-entry FIFO.
module ram_read_streamer #(
  parameter int unsigned AW = 11,
  parameter int unsigned MW = 8,
  parameter int unsigned DW = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW-1:0]    stride,
  input  logic [AW:0]      num_words,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    ram_addr,
  output logic [MW-1:0]    ram_we,
  input  logic [MW*DW-1:0] ram_q,
  output logic [MW*DW-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned WW    = MW * DW;
  localparam int unsigned Depth = 4;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   stride_q, stride_d;
  logic [AW:0]     remaining_q, remaining_d;
  // Set for the cycle in which ram_q carries the word of a read issued last cycle.
  logic            rd_vld_q;

  logic [WW-1:0]   mem_q [Depth];
  logic [1:0]      wr_ptr_q, rd_ptr_q;
  logic [2:0]      count_q, count_d;

  logic            issue;
  logic            pop;
  logic            fifo_we;
  logic [2:0]      credit_used;

  assign ram_we    = '0;
  assign ram_addr  = addr_q;
  assign out_valid = (count_q != 3'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign busy      = (state_q == StRun) || (state_q == StDrain);
  assign done      = (state_q == StDone);

  always_comb begin
    pop         = out_valid & out_ready;
    fifo_we     = rd_vld_q;
    // FIFO occupancy plus reads still in flight must never exceed the FIFO depth.
    credit_used = count_q + {2'b00, rd_vld_q};
    issue       = (state_q == StRun) && (credit_used < 3'(Depth)) && (remaining_q != '0);
    count_d     = count_q + {2'b00, fifo_we} - {2'b00, pop};
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    remaining_d = remaining_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (num_words == '0) begin
            state_d = StDone;
          end else begin
            addr_d      = base_addr;
            stride_d    = stride;
            remaining_d = num_words;
            state_d     = StRun;
          end
        end
      end
      StRun: begin
        if (issue) begin
          addr_d      = addr_q + stride_q;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == (AW+1)'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Look at the post-pop count so done lands the cycle after the last handshake.
        if (!rd_vld_q && (count_d == 3'd0)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      stride_q    <= '0;
      remaining_q <= '0;
      rd_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      remaining_q <= remaining_d;
      rd_vld_q    <= issue;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_we) begin
        mem_q[wr_ptr_q] <= ram_q;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      count_q <= count_d;
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(fifo_we && !pop && (count_q == 3'(Depth))));

endmodule

// File: tb/tb_ram_read_streamer.sv
// Randomised scoreboard bench for ram_read_streamer with a behavioural RAM and a
// reference model that predicts each word as mem[(base + i*stride) mod 2^AW].
module tb_ram_read_streamer;

  localparam int AW    = 11;
  localparam int MW    = 8;
  localparam int DW    = 8;
  localparam int WW    = MW * DW;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] stride = '0;
  logic [AW:0]   num_words = '0;
  logic          busy, done;
  logic [AW-1:0] ram_addr;
  logic [MW-1:0] ram_we;
  logic [WW-1:0] ram_q = '0;
  logic [WW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;

  ram_read_streamer #(.AW(AW), .MW(MW), .DW(DW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .base_addr (base_addr),
    .stride    (stride),
    .num_words (num_words),
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_q     (ram_q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] mem [DEPTH];
  always @(posedge clk) ram_q <= mem[ram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            total = 0;
  int            bad = 0;
  logic [WW-1:0] exp_q [$];
  int            hs_cnt = 0;
  int            last_hs = 0;
  bit            zl = 1'b0;
  int            rdy_mode = 0;  // 0 high, 1 low, 2 random, 3 driven by the stimulus
  bit            prev_stall = 1'b0;
  logic [WW-1:0] prev_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks done/stability rules.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word: got %h want none (cycle %0d)", out_data, cyc);
        end else begin
          chk("data", out_data, exp_q.pop_front());
        end
        hs_cnt++;
        last_hs = cyc;
      end
      if (done) begin
        chk("done_empty", 64'(exp_q.size()), 64'd0);
        chk("ram_we", 64'(ram_we), 64'd0);
        if (!zl) chk("done_timing", 64'(cyc), 64'(last_hs + 1));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'b0;
        2: out_ready = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  // Pulses start for one cycle (cycle T = returned t0) and queues the predicted words.
  task automatic send(input int b, input int s, input int n, output int t0);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = AW'(b);
    stride    = AW'(s);
    num_words = (AW+1)'(n);
    t0        = cyc;
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(b + i * s) % DEPTH]);
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = AW'($urandom);
    stride    = AW'($urandom);
    num_words = (AW+1)'($urandom);
  endtask

  task automatic wait_done(input int bound, output int dc);
    dc = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        break;
      end
    end
    total++;
    if (dc < 0) begin
      bad++;
      $display("FAIL done_timeout: got no done want done within %0d cycles", bound);
    end
  endtask

  int t0, dc, hs0;
  logic [AW-1:0] a0;
  logic [AW-1:0] wrap_exp [3];

  initial begin
    for (int a = 0; a < DEPTH; a++) mem[a] = {32'($urandom), 21'h0, 11'(a)};
    wrap_exp[0] = 11'h7FE;
    wrap_exp[1] = 11'h001;
    wrap_exp[2] = 11'h004;

    #1 resetn = 1'b0;
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_addr", 64'(ram_addr), 64'd0);
    chk("rst_we", 64'(ram_we), 64'd0);
    chk("rst_data", out_data, 64'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Basic stream with fixed latency checks.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    send(32'h010, 1, 4, t0);
    for (int k = 0; k < 4; k++) begin
      chk("basic_addr", 64'(ram_addr), 64'(32'h010 + k));
      chk("basic_valid", 64'(out_valid), 64'(k >= 2));
      @(posedge clk);
      #1;
    end
    wait_done(50, dc);
    chk("basic_done_at", 64'(dc), 64'(t0 + 7));

    // Backpressure: out_ready low for T+2..T+9.
    rdy_mode  = 3;
    out_ready = 1'b1;
    hs0 = hs_cnt;
    send(32'h100, 2, 8, t0);
    @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_stall_addr_t6", 64'(ram_addr), 64'h108);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_stall_addr_t9", 64'(ram_addr), 64'h108);
    chk("bp_valid", 64'(out_valid), 64'd1);
    chk("bp_no_hs", 64'(hs_cnt - hs0), 64'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(100, dc);
    chk("bp_words", 64'(hs_cnt - hs0), 64'd8);
    rdy_mode = 0;

    // Address wrap-around.
    send(32'h7FE, 3, 3, t0);
    for (int k = 0; k < 3; k++) begin
      chk("wrap_addr", 64'(ram_addr), 64'(wrap_exp[k]));
      @(posedge clk);
      #1;
    end
    wait_done(50, dc);
    chk("wrap_done_at", 64'(dc), 64'(t0 + 6));

    // Zero length.
    @(posedge clk);
    a0 = ram_addr;
    zl = 1'b1;
    send(32'h005, 7, 0, t0);
    wait_done(10, dc);
    chk("zero_done_at", 64'(dc), 64'(t0 + 1));
    chk("zero_busy", 64'(busy), 64'd0);
    chk("zero_addr", 64'(ram_addr), 64'(a0));
    @(posedge clk);
    zl = 1'b0;

    // Second start during RUN is ignored.
    send(32'h200, 5, 6, t0);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = 11'h003;
    stride    = 11'h001;
    num_words = 12'd3;
    @(posedge clk);
    #1 start = 1'b0;
    chk("ign_busy", 64'(busy), 64'd1);
    wait_done(50, dc);
    chk("ign_done_at", 64'(dc), 64'(t0 + 9));

    // Reset in the middle of a transfer.
    rdy_mode = 2;
    hs0 = hs_cnt;
    send(32'h050, 9, 6, t0);
    dc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (hs_cnt - hs0 >= 2) begin
        dc = i;
        break;
      end
    end
    chk("rst_mid_reached", 64'(dc >= 0), 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_addr", 64'(ram_addr), 64'd0);
    chk("rst_mid_data", out_data, 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    resetn   = 1'b1;
    rdy_mode = 0;
    hs0 = hs_cnt;
    send(32'h060, 1, 2, t0);
    wait_done(50, dc);
    chk("post_rst_done_at", 64'(dc), 64'(t0 + 5));
    chk("post_rst_words", 64'(hs_cnt - hs0), 64'd2);

    // Random commands with random backpressure.
    for (int r = 0; r < 25; r++) begin
      rdy_mode = ($urandom_range(0, 1) != 0) ? 2 : 0;
      send(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
           int'($urandom_range(1, 20)), t0);
      wait_done(500, dc);
    end

    // Full-range length.
    rdy_mode = 2;
    hs0 = hs_cnt;
    send(int'($urandom_range(0, DEPTH - 1)), 1, DEPTH, t0);
    wait_done(20000, dc);
    chk("full_words", 64'(hs_cnt - hs0), 64'(DEPTH));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
